// File: rtl/set_cmp_ctrl_if.sv
// Request/response bundle between the issue logic (master) and the set-compare
// sequencer (slave): two compare request ports and one result channel.
interface set_cmp_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [2:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [2:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [31:0]      rsp_set;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_set,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_set,
    output rsp_ready
  );
endinterface

// File: rtl/set_cmp_ctrl.sv
// Set-condition compare sequencer: round-robin arbitration of two requesters onto
// one SLICE-bit subtractor, rippled LSB-first over WIDTH/SLICE cycles.
module set_cmp_ctrl #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  set_cmp_ctrl_if.slave bus,
  output logic          busy
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = $clog2(NSLICE) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  state_t          state, state_nx;
  req_t [1:0]      req;
  logic [1:0]      req_vld;
  logic [1:0]      ready;
  logic            gnt_id;
  logic            last_grant;
  logic            accept;
  logic            rsp_vld;

  req_t            cur;
  logic            cur_id;
  logic [CW-1:0]   slice_cnt;
  logic            carry;
  logic            zero;
  logic [31:0]     rsp_set_q;

  logic [SLICE:0]  slice_sum;
  logic            cout_nx;
  logic            zero_nx;
  logic            last_slice;

  assign req_vld = {bus.req1_valid, bus.req0_valid};
  assign req[0]  = {bus.req0_op, bus.req0_a, bus.req0_b};
  assign req[1]  = {bus.req1_op, bus.req1_a, bus.req1_b};

  // Port 1 wins a tie only when port 0 took the previous grant.
  assign gnt_id = req_vld[1] & (~req_vld[0] | ~last_grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = '0;
    rsp_vld  = 1'b0;
    busy     = 1'b1;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        busy  = 1'b0;
        // Gate with rst_n so both readies drop the instant reset asserts.
        ready = {gnt_id & req_vld[1], ~gnt_id & req_vld[0]} & {2{rst_n}};
        accept = |ready;
        if (accept) state_nx = CALC;
      end
      CALC: if (last_slice) state_nx = DONE;
      DONE: begin
        rsp_vld = 1'b1;
        if (bus.rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operands shift right each CALC cycle so the low slice is always the live one.
  assign slice_sum  = {1'b0, cur.a[SLICE-1:0]} + {1'b0, ~cur.b[SLICE-1:0]}
                    + {{SLICE{1'b0}}, carry};
  assign cout_nx    = slice_sum[SLICE];
  assign zero_nx    = zero & (slice_sum[SLICE-1:0] == '0);
  assign last_slice = (slice_cnt == CW'(NSLICE - 1));

  function automatic logic [31:0] set_word(input logic [2:0] op,
                                           input logic eq, input logic lt);
    logic r;
    case (op)
      3'd0:    r = eq;
      3'd1:    r = ~eq;
      3'd2:    r = lt;
      3'd3:    r = ~lt & ~eq;
      3'd4:    r = lt | eq;
      3'd5:    r = ~lt;
      default: r = 1'b0;
    endcase
    return {31'd0, r};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur        <= '0;
      cur_id     <= 1'b0;
      last_grant <= 1'b1;
      slice_cnt  <= '0;
      carry      <= 1'b1;
      zero       <= 1'b1;
      rsp_set_q  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cur        <= req[gnt_id];
          cur_id     <= gnt_id;
          last_grant <= gnt_id;
          slice_cnt  <= '0;
          carry      <= 1'b1;
          zero       <= 1'b1;
        end
        CALC: begin
          cur.a     <= cur.a >> SLICE;
          cur.b     <= cur.b >> SLICE;
          carry     <= cout_nx;
          zero      <= zero_nx;
          slice_cnt <= slice_cnt + 1'b1;
          if (last_slice) rsp_set_q <= set_word(cur.op, zero_nx, ~cout_nx);
        end
        default: ;
      endcase
    end
  end

  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];
  assign bus.rsp_valid  = rsp_vld;
  assign bus.rsp_id     = cur_id;
  assign bus.rsp_set    = rsp_set_q;
endmodule

// File: tb/tb_set_cmp_ctrl.sv
// Bench for set_cmp_ctrl: cycle model of arbitration/latency with plain unsigned
// compares, checked every negedge, plus directed vectors with literal results.
module tb_set_cmp_ctrl;
  localparam int WIDTH  = 32;
  localparam int SLICE  = 8;
  localparam int NSLICE = WIDTH / SLICE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  set_cmp_ctrl_if #(.WIDTH(WIDTH)) bus();
  set_cmp_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm, input int cyc);
    n_chk++;
    n_fail++;
    $display("FAIL %s: no event within %0d cycles at %0t", nm, cyc, $time);
  endtask

  function automatic logic [31:0] ref_set(input logic [2:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
    logic r;
    case (op)
      3'd0:    r = (a == b);
      3'd1:    r = (a != b);
      3'd2:    r = (a < b);
      3'd3:    r = (a > b);
      3'd4:    r = (a <= b);
      3'd5:    r = (a >= b);
      default: r = 1'b0;
    endcase
    return {31'd0, r};
  endfunction

  // Model: 0 idle, 1 computing, 2 holding a result. m_last=1 favours req0.
  int          m_st = 0;
  int          m_cnt = 0;
  bit          m_last = 1'b1;
  bit          m_id = 1'b0;
  logic [31:0] m_set = '0;
  int          grant_log[$];
  bit          g1, e0, e1;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
      chk("rst_ready1", {31'd0, bus.req1_ready}, 32'd0);
      chk("rst_rsp_set", bus.rsp_set, 32'd0);
      chk("rst_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
      m_st = 0;
      m_last = 1'b1;
    end else begin
      g1 = 1'b0; e0 = 1'b0; e1 = 1'b0;
      if (m_st == 0) begin
        g1 = bus.req1_valid && (!bus.req0_valid || !m_last);
        e1 = g1;
        e0 = bus.req0_valid && !g1;
      end
      chk("busy", {31'd0, busy}, {31'd0, m_st != 0});
      chk("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, m_st == 2});
      chk("req0_ready", {31'd0, bus.req0_ready}, {31'd0, e0});
      chk("req1_ready", {31'd0, bus.req1_ready}, {31'd0, e1});
      if (m_st == 2) begin
        chk("rsp_set", bus.rsp_set, m_set);
        chk("rsp_id", {31'd0, bus.rsp_id}, {31'd0, m_id});
      end
      case (m_st)
        0: if (e0 || e1) begin
          m_id   = g1;
          m_last = g1;
          m_set  = g1 ? ref_set(bus.req1_op, bus.req1_a, bus.req1_b)
                      : ref_set(bus.req0_op, bus.req0_a, bus.req0_b);
          grant_log.push_back(int'(g1));
          m_st = 1;
          m_cnt = 0;
        end
        1: begin
          m_cnt++;
          if (m_cnt == NSLICE) m_st = 2;
        end
        default: if (bus.rsp_ready) m_st = 0;
      endcase
    end
  end

  task automatic drive(input int p, input bit v, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  // Returns after the accept edge (+1) with the request withdrawn.
  task automatic wait_accept(input int p, input string nm, output int waited);
    waited = 0;
    forever begin
      @(negedge clk);
      if ((p == 0 && bus.req0_ready) || (p == 1 && bus.req1_ready)) break;
      waited++;
      if (waited > 40) begin timeout(nm, waited); break; end
    end
    @(posedge clk); #1;
    if (p == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string nm, output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) begin lat = i; break; end
    end
    if (lat == 0) timeout(nm, 40);
  endtask

  task automatic issue(input string nm, input int p, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int w, lat;
    drive(p, 1'b1, op, a, b);
    wait_accept(p, nm, w);
    chk({nm, "_acc_wait"}, w, 0);
    wait_rsp(nm, lat);
    chk({nm, "_latency"}, lat, NSLICE);
    chk({nm, "_set"}, bus.rsp_set, exp);
    chk({nm, "_id"}, {31'd0, bus.rsp_id}, p);
    @(posedge clk); #1;
  endtask

  int dut_log[$];
  int w, lat, n;
  logic [31:0] held_set;

  initial begin
    drive(0, 1'b0, 3'd0, '0, '0);
    drive(1, 1'b0, 3'd0, '0, '0);
    bus.rsp_ready = 1'b1;
    #1;
    chk("init_busy", {31'd0, busy}, 32'd0);
    chk("init_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    issue("seq_eq",    0, 3'd0, 32'h12345678, 32'h12345678, 32'd1);
    issue("slt_1_max", 1, 3'd2, 32'h00000001, 32'hFFFFFFFF, 32'd1);
    issue("sgt_1_max", 1, 3'd3, 32'h00000001, 32'hFFFFFFFF, 32'd0);
    issue("sge_ones",  1, 3'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1);
    issue("sle_unsgn", 1, 3'd4, 32'h80000000, 32'h7FFFFFFF, 32'd0);
    issue("slt_b0",    0, 3'd2, 32'hDEADBEEF, 32'h00000000, 32'd0);
    issue("slt_a0",    0, 3'd2, 32'h00000000, 32'h00000100, 32'd1);
    issue("sne_low",   0, 3'd1, 32'h00010000, 32'h00000000, 32'd1);
    issue("illegal7",  0, 3'd7, 32'd3, 32'd3, 32'd0);
    issue("illegal6",  1, 3'd6, 32'd9, 32'd2, 32'd0);

    // Hold the result in DONE while req1 waits.
    bus.rsp_ready = 1'b0;
    drive(0, 1'b1, 3'd0, 32'h000000AA, 32'h000000AA);
    wait_accept(0, "hold_acc", w);
    drive(1, 1'b1, 3'd0, 32'd1, 32'd2);
    wait_rsp("hold_rsp", lat);
    held_set = bus.rsp_set;
    chk("hold_first_set", held_set, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("hold_set", bus.rsp_set, 32'd1);
      chk("hold_id", {31'd0, bus.rsp_id}, 32'd0);
      chk("hold_ready1", {31'd0, bus.req1_ready}, 32'd0);
      chk("hold_busy", {31'd0, busy}, 32'd1);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_busy", {31'd0, busy}, 32'd0);
    chk("release_ready1", {31'd0, bus.req1_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    chk("after_release_busy", {31'd0, busy}, 32'd1);
    wait_rsp("hold_next", lat);
    chk("hold_next_set", bus.rsp_set, 32'd0);
    chk("hold_next_id", {31'd0, bus.rsp_id}, 32'd1);
    @(posedge clk); #1;

    // Both ports continuously valid; last grant was req1.
    grant_log.delete();
    drive(0, 1'b1, 3'd1, 32'd5, 32'd6);
    drive(1, 1'b1, 3'd1, 32'd5, 32'd6);
    n = 0;
    while (dut_log.size() < 4) begin
      @(negedge clk);
      if (bus.req0_ready) dut_log.push_back(0);
      if (bus.req1_ready) dut_log.push_back(1);
      n++;
      if (n > 80) begin timeout("rr_grants", n); break; end
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 3'd0, '0, '0);
    drive(1, 1'b0, 3'd0, '0, '0);
    chk("rr_count", dut_log.size(), 4);
    for (int i = 0; i < dut_log.size() && i < 4; i++) begin
      chk("rr_dut_order", dut_log[i], i % 2);
      chk("rr_model_order", grant_log[i], i % 2);
    end
    n = 0;
    while (busy) begin
      @(posedge clk); #1;
      n++;
      if (n > 40) begin timeout("rr_drain", n); break; end
    end
    @(posedge clk); #1;

    // Async reset during the 2nd CALC cycle.
    drive(1, 1'b0, 3'd0, '0, '0);
    drive(0, 1'b1, 3'd2, 32'd1, 32'd2);
    wait_accept(0, "rst_acc", w);
    drive(1, 1'b1, 3'd3, 32'd4, 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("async_ready0", {31'd0, bus.req0_ready}, 32'd0);
    chk("async_ready1", {31'd0, bus.req1_ready}, 32'd0);
    chk("async_rsp_set", bus.rsp_set, 32'd0);
    chk("async_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
    @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    drive(0, 1'b1, 3'd0, 32'd9, 32'd9);
    @(negedge clk);
    chk("post_rst_grant0", {31'd0, bus.req0_ready}, 32'd1);
    chk("post_rst_grant1", {31'd0, bus.req1_ready}, 32'd0);
    @(posedge clk); #1;
    drive(0, 1'b0, 3'd0, '0, '0);
    drive(1, 1'b0, 3'd0, '0, '0);
    wait_rsp("post_rst_rsp", lat);
    chk("post_rst_lat", lat, NSLICE);
    chk("post_rst_set", bus.rsp_set, 32'd1);
    chk("post_rst_id", {31'd0, bus.rsp_id}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/set_cmp_ctrl.md
Name: set_cmp_ctrl

Overview:
- Sequencing and arbitration controller for the set-condition compare unit (seq/sne/slt/sgt/sle/sge).
- Shares one narrow SLICE-bit subtractor between two requester ports. Each accepted compare is run as a multi-cycle, LSB-first ripple of A + ~B + 1.
- Returns a 32-bit set word (0 or 1) over a valid/ready response channel.
- Sits between the issue logic and the register writeback path.

Parameters:
- WIDTH, 32, operand width in bits; must be an integer multiple of SLICE.
- SLICE, 8, subtractor slice width per cycle; compute takes NSLICE = WIDTH/SLICE cycles.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has a compare pending
- req0_ready  out  1  requester 0 accepted this cycle
- req0_op  in  3  compare opcode
- req0_a  in  WIDTH  operand A
- req0_b  in  WIDTH  operand B
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  index of the requester that owns the result
- rsp_set  out  32  result word, 32'd1 or 32'd0
- busy  out  1  high whenever state != IDLE

Behaviour:
- Opcodes: 0 SEQ, 1 SNE, 2 SLT, 3 SGT, 4 SLE, 5 SGE. Codes 6 and 7 are illegal: the request is accepted normally and returns rsp_set = 0.
- Comparison is unsigned.
  - Compute diff = A + ~B + 1. cout = final carry.
  - eq = (diff == 0); lt = ~cout.
  - SEQ = eq; SNE = ~eq; SLT = lt; SGE = ~lt; SLE = lt | eq; SGT = ~lt & ~eq.
- FSM states: IDLE, CALC, DONE.
  - IDLE: grant is combinational. The req_ready of the granted port = valid of that port; the other ready = 0.
  - An accept is a rising edge with reqN_valid & reqN_ready. On accept, latch op, A, B and id; clear slice_cnt, carry = 1, zero = 1; go to CALC.
  - CALC: one slice per cycle, starting at the LSB slice.
    - {carry, d} = A_slice + ~B_slice + carry.
    - zero &= (d == 0).
    - slice_cnt increments.
    - After NSLICE CALC edges, latch rsp_set and go to DONE.
  - DONE: rsp_valid = 1; rsp_set and rsp_id are held stable while rsp_ready = 0. On rsp_valid & rsp_ready, go to IDLE.
- Latency and throughput:
  - Accept at edge k; rsp_valid is first high after edge k+NSLICE (defaults: 4 cycles).
  - No new accept in the same cycle as a response handshake. Minimum issue interval is NSLICE+2 cycles.
- Arbitration is round-robin with a last_grant pointer. Reset value favours req0.
  - Only one valid: that port is granted.
  - Both valid: the port not granted last is granted.
  - The pointer updates only on accept.
- Requesters must hold valid and payload until ready. A requester dropping valid before accept is not an error.
- req_ready is never asserted outside IDLE.
- Async reset (rst_n low), including mid-CALC or mid-DONE, forces:
  - state IDLE
  - rsp_valid = 0, rsp_set = 0, rsp_id = 0
  - busy = 0, both req_ready = 0
  - last_grant pointer favouring req0
  - any in-flight compare is discarded with no response
- Boundary cases:
  - A = B: zero = 1 and cout = 1.
  - B = 0: cout = 1 for any A.
  - A = 0, B != 0: lt = 1.
  - All-ones operands must not overflow any counter.
  - slice_cnt width = clog2(NSLICE)+1.

Test Plan:
- Reset then req0 SEQ A=0x12345678, B=0x12345678: accept on first valid edge → rsp_valid 4 cycles later, rsp_set=1, rsp_id=0.
- req1 SLT A=0x00000001, B=0xFFFFFFFF → rsp_set=1. Repeat as SGT → 0. Repeat as SGE with A=B=0xFFFFFFFF → 1. Repeat as SLE with A=0x80000000, B=0x7FFFFFFF → 0 (unsigned).
- Both ports valid continuously with SNE (A=5, B=6): grants alternate 0,1,0,1. Every rsp_set=1, and rsp_id matches the grant order.
- Hold rsp_ready=0 for 10 cycles in DONE → rsp_valid, rsp_set and rsp_id stay stable, both req_ready stay 0, busy=1. Release → IDLE next cycle, and the next accept occurs no earlier than the following cycle.
- Assert rst_n=0 during the 2nd CALC cycle → outputs clear immediately with no clock edge needed. No response is emitted; the next request after reset is granted to req0.
- Illegal opcode 7 with A=3, B=3 → accepted, rsp_set=0 after 4 cycles.
